fetch_ctrl_pp: RTL and testbench
================================

// Module: fetch_ctrl_pp
// PURPOSE
//  Instruction-fetch sequencer for the pipelined processor.
//  - Owns the PC and drives the word address into the combinational instruction ROM.
//  - Registers ROM output into the IF/ID pipeline register; applies stall, flush and redirect.
//  - Gates fetch through an IDLE/RUN/HALT state machine and keeps fetch/bubble counters.
// PARAMETERS
//  RESET_PC  32'd0   PC loaded on reset and on start
//  PROG_LEN  32'd21  first word address past the program; fetch at PC>=PROG_LEN halts
//  CNT_W     16      width of performance counters (saturating)
// PORTS
//  clk            in   1      clock, all state on rising edge
//  rst            in   1      asynchronous, active-high reset
//  start          in   1      pulse: leave IDLE/HALT, PC<=RESET_PC, begin fetch
//  stall          in   1      hazard unit: hold PC and IF/ID contents
//  branch_taken   in   1      ID-stage branch resolved taken
//  branch_imm     in   16     branch offset, words, signed
//  jump           in   1      ID-stage jump
//  jump_addr      in   26     jump target, word address, zero-extended
//  rom_instr      in   32     instruction returned by ROM for rom_addr (same cycle)
//  rom_addr       out  32     word address to ROM (= pc)
//  if_id_instr    out  32     IF/ID instruction (32'h0 when bubble)
//  if_id_pc       out  32     IF/ID PC of that instruction
//  if_id_valid    out  1      IF/ID holds a real instruction
//  halted         out  1      state==HALT
//  fetch_cnt      out  CNT_W  instructions placed into IF/ID with valid=1
//  bubble_cnt     out  CNT_W  bubbles inserted by flush/halt (stall cycles not counted)
// BEHAVIOUR
//  Reset (async): state=IDLE, pc=RESET_PC, if_id_instr=0, if_id_pc=0, if_id_valid=0,
//   halted=0, counters=0. Reset asserted mid-run clears everything immediately.
//  rom_addr=pc combinationally; ROM read has zero latency; IF/ID updates at next edge.
//  IDLE: no fetch, IF/ID valid=0, pc held. start -> RUN with pc=RESET_PC; next edge fetches RESET_PC.
//  RUN, per edge, priority order:
//   1 stall=1: pc, IF/ID unchanged; branch_taken/jump ignored (ID re-asserts after stall).
//   2 jump=1 (wins over branch_taken): pc<={6'b0,jump_addr}; IF/ID<=bubble.
//   3 branch_taken=1: pc<=if_id_pc+1+sext(branch_imm); IF/ID<=bubble.
//   4 pc>=PROG_LEN: IF/ID<=bubble, pc held, state->HALT.
//   5 else: IF/ID<={rom_instr,pc,valid=1}; pc<=pc+1.
//  Redirect penalty: exactly one bubble; target instruction is in IF/ID two edges after
//   the redirect is sampled.
//  Redirect/halt is evaluated before the bound check: a branch out of the program while pc==PROG_LEN
//   redirects, no halt.
//  HALT: IF/ID valid=0, pc held, stall/redirect ignored; start -> RUN as from IDLE.
//  start in RUN: ignored.
//  PC arithmetic is mod 2^32; negative offsets wrap; no range check on targets.
//  Counters: fetch_cnt +1 on case 5; bubble_cnt +1 on cases 2/3/4; both saturate at all-ones.
// TESTING
//  Reset, start -> IF/ID shows mem0..3 on edges 1..4, pc=4, fetch_cnt=4, valid=1.
//  stall high 3 cycles at pc=6 -> IF/ID holds PC5 instr, pc stays 6, counters frozen.
//  if_id_pc=10, branch_taken, imm=3 -> one bubble (valid=0), then if_id_pc=14; bubble_cnt+1.
//  jump, jump_addr=19, with branch_taken=1 simultaneously -> jump wins; next valid if_id_pc=19.
//  Run to pc=21 (PROG_LEN) -> bubble, halted=1, pc stays 21; start -> re-fetch from 0.
//  stall+jump same cycle -> no redirect; rst mid-RUN -> all outputs zero, state IDLE same cycle.

Source files
------------

// File: rtl/fetch_ctrl_pp.sv
// Instruction-fetch sequencer: owns the PC, drives the ROM address and loads the IF/ID register.
// Handles stall, jump/branch redirect (one bubble), end-of-program halt and saturating counters.
module fetch_ctrl_pp #(
   parameter logic [31:0] RESET_PC = 32'd0,
   parameter logic [31:0] PROG_LEN = 32'd21,
   parameter int          CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stall,
   input  logic             branch_taken,
   input  logic [15:0]      branch_imm,
   input  logic             jump,
   input  logic [25:0]      jump_addr,
   input  logic [31:0]      rom_instr,
   output logic [31:0]      rom_addr,
   output logic [31:0]      if_id_instr,
   output logic [31:0]      if_id_pc,
   output logic             if_id_valid,
   output logic             halted,
   output logic [CNT_W-1:0] fetch_cnt,
   output logic [CNT_W-1:0] bubble_cnt
);

   typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

   state_t           state, state_nxt;
   logic [31:0]      pc, pc_nxt;
   logic [31:0]      instr_nxt, ifpc_nxt;
   logic             valid_nxt;
   logic             inc_fetch, inc_bubble;
   logic [31:0]      branch_target;

   assign rom_addr      = pc;
   assign halted        = (state == HALT);
   assign branch_target = if_id_pc + 32'd1 + {{16{branch_imm[15]}}, branch_imm};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         if_id_instr <= 32'h0;
         if_id_pc    <= 32'h0;
         if_id_valid <= 1'b0;
         fetch_cnt   <= '0;
         bubble_cnt  <= '0;
      end else begin
         state       <= state_nxt;
         pc          <= pc_nxt;
         if_id_instr <= instr_nxt;
         if_id_pc    <= ifpc_nxt;
         if_id_valid <= valid_nxt;
         if (inc_fetch && fetch_cnt != {CNT_W{1'b1}})
            fetch_cnt <= fetch_cnt + CNT_W'(1);
         if (inc_bubble && bubble_cnt != {CNT_W{1'b1}})
            bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
   end

   always_comb begin
      state_nxt  = state;
      pc_nxt     = pc;
      instr_nxt  = if_id_instr;
      ifpc_nxt   = if_id_pc;
      valid_nxt  = if_id_valid;
      inc_fetch  = 1'b0;
      inc_bubble = 1'b0;
      case (state)
         RUN: begin
            if (stall) begin
               // hold everything; ID re-presents any redirect once the stall clears
            end else if (jump || branch_taken) begin
               pc_nxt     = jump ? {6'b0, jump_addr} : branch_target;
               instr_nxt  = 32'h0;
               ifpc_nxt   = 32'h0;
               valid_nxt  = 1'b0;
               inc_bubble = 1'b1;
            end else if (pc >= PROG_LEN) begin
               instr_nxt  = 32'h0;
               ifpc_nxt   = 32'h0;
               valid_nxt  = 1'b0;
               inc_bubble = 1'b1;
               state_nxt  = HALT;
            end else begin
               pc_nxt    = pc + 32'd1;
               instr_nxt = rom_instr;
               ifpc_nxt  = pc;
               valid_nxt = 1'b1;
               inc_fetch = 1'b1;
            end
         end
         default: begin
            // IDLE and HALT present a bubble and wait for start
            instr_nxt = 32'h0;
            ifpc_nxt  = 32'h0;
            valid_nxt = 1'b0;
            if (start) begin
               state_nxt = RUN;
               pc_nxt    = RESET_PC;
            end
         end
      endcase
   end

endmodule

// File: tb/tb_fetch_ctrl_pp.sv
// Directed bench for fetch_ctrl_pp with a combinational ROM returning 32'hA000_0000 | address.
module tb_fetch_ctrl_pp;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, stall, branch_taken, jump;
   logic [15:0] branch_imm;
   logic [25:0] jump_addr;
   logic [31:0] rom_instr, rom_addr, if_id_instr, if_id_pc;
   logic        if_id_valid, halted;
   logic [15:0] fetch_cnt, bubble_cnt;

   int checks = 0;
   int errors = 0;

   fetch_ctrl_pp dut (
      .clk(clk), .rst(rst), .start(start), .stall(stall),
      .branch_taken(branch_taken), .branch_imm(branch_imm),
      .jump(jump), .jump_addr(jump_addr), .rom_instr(rom_instr),
      .rom_addr(rom_addr), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
      .if_id_valid(if_id_valid), .halted(halted),
      .fetch_cnt(fetch_cnt), .bubble_cnt(bubble_cnt)
   );

   assign rom_instr = 32'hA000_0000 | rom_addr;

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Checks a valid fetched instruction and the PC that follows it.
   task automatic chk_fetch(input string tag, input logic [31:0] ipc, input logic [31:0] npc);
      chk({tag, "_valid"}, {31'b0, if_id_valid}, 32'd1);
      chk({tag, "_ifpc"}, if_id_pc, ipc);
      chk({tag, "_instr"}, if_id_instr, 32'hA000_0000 | ipc);
      chk({tag, "_pc"}, rom_addr, npc);
   endtask

   task automatic chk_bubble(input string tag, input logic [31:0] npc, input logic [15:0] bcnt);
      chk({tag, "_valid"}, {31'b0, if_id_valid}, 32'd0);
      chk({tag, "_instr"}, if_id_instr, 32'h0);
      chk({tag, "_pc"}, rom_addr, npc);
      chk({tag, "_bcnt"}, {16'b0, bubble_cnt}, {16'b0, bcnt});
   endtask

   initial begin
      rst = 1'b1; start = 0; stall = 0; branch_taken = 0; jump = 0;
      branch_imm = 16'h0; jump_addr = 26'h0;
      #12 rst = 1'b0;
      #1;
      chk("rst_valid", {31'b0, if_id_valid}, 32'd0);
      chk("rst_instr", if_id_instr, 32'h0);
      chk("rst_ifpc", if_id_pc, 32'h0);
      chk("rst_pc", rom_addr, 32'h0);
      chk("rst_halted", {31'b0, halted}, 32'd0);
      chk("rst_cnts", {fetch_cnt, bubble_cnt}, 32'h0);
      tick();
      chk("idle_valid", {31'b0, if_id_valid}, 32'd0);

      start = 1; tick(); start = 0;
      chk("start_valid", {31'b0, if_id_valid}, 32'd0);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk_fetch("seq", k, k + 1);
      end
      chk("seq_fcnt", {16'b0, fetch_cnt}, 32'd4);

      tick(); tick();
      chk_fetch("pre_stall", 5, 6);
      stall = 1;
      for (int k = 0; k < 3; k++) begin
         jump = (k == 1); jump_addr = 26'd3;
         tick();
         chk_fetch("stall", 5, 6);
         chk("stall_cnts", {fetch_cnt, bubble_cnt}, {16'd6, 16'd0});
      end
      stall = 0; jump = 0;

      for (int k = 0; k < 5; k++) tick();
      chk_fetch("pre_br", 10, 11);
      branch_taken = 1; branch_imm = 16'd3;
      tick();
      branch_taken = 0;
      chk_bubble("br", 14, 1);
      tick();
      chk_fetch("br_tgt", 14, 15);
      chk("br_fcnt", {16'b0, fetch_cnt}, 32'd12);

      jump = 1; jump_addr = 26'd19; branch_taken = 1; branch_imm = 16'hFFFB;
      tick();
      jump = 0; branch_taken = 0;
      chk_bubble("jmp", 19, 2);
      tick();
      chk_fetch("jmp_tgt", 19, 20);
      tick();
      chk_fetch("last", 20, 21);
      tick();
      chk_bubble("halt", 21, 3);
      chk("halt_flag", {31'b0, halted}, 32'd1);
      stall = 1; jump = 1; jump_addr = 26'd2;
      tick();
      stall = 0; jump = 0;
      chk("halt_hold_pc", rom_addr, 32'd21);
      chk("halt_hold_flag", {31'b0, halted}, 32'd1);

      start = 1; tick(); start = 0;
      chk("restart_flag", {31'b0, halted}, 32'd0);
      chk("restart_pc", rom_addr, 32'd0);
      tick();
      chk_fetch("restart", 0, 1);
      start = 1; tick(); start = 0;
      chk_fetch("start_in_run", 1, 2);
      chk("run_fcnt", {16'b0, fetch_cnt}, 32'd16);

      jump = 1; jump_addr = 26'd20; tick(); jump = 0;
      chk_bubble("jmp20", 20, 4);
      tick();
      chk_fetch("at_end", 20, 21);
      branch_taken = 1; branch_imm = 16'hFFF0;
      tick();
      branch_taken = 0;
      chk_bubble("br_at_end", 5, 5);
      chk("br_at_end_flag", {31'b0, halted}, 32'd0);
      tick();
      chk_fetch("back", 5, 6);
      branch_taken = 1; branch_imm = 16'hFFF9;
      tick();
      branch_taken = 0;
      chk_bubble("wrap", 32'hFFFF_FFFF, 6);
      tick();
      chk_bubble("wrap_halt", 32'hFFFF_FFFF, 7);
      chk("wrap_halt_flag", {31'b0, halted}, 32'd1);

      start = 1; tick(); start = 0;
      tick(); tick();
      chk_fetch("pre_rst", 1, 2);
      #2 rst = 1'b1;
      #1;
      chk("mrst_valid", {31'b0, if_id_valid}, 32'd0);
      chk("mrst_instr", if_id_instr, 32'h0);
      chk("mrst_ifpc", if_id_pc, 32'h0);
      chk("mrst_pc", rom_addr, 32'h0);
      chk("mrst_cnts", {fetch_cnt, bubble_cnt}, 32'h0);
      rst = 1'b0;
      tick();
      chk("mrst_idle", {31'b0, if_id_valid}, 32'd0);
      chk("mrst_idle_pc", rom_addr, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
